fp_alu_align_pipe: RTL and testbench
====================================

Name: fp_alu_align_pipe

Overview:
- Multi-lane, elastic floating-point alignment stage for the FP ALU add path.
- Per lane:
  - picks the larger-exponent operand from the sign of the exponent difference;
  - arithmetic-shifts the smaller mantissa right by the clamped magnitude;
  - produces guard/round/sticky bits for the downstream rounding stage.
- Sits between the exponent-compare stage and the mantissa add stage.
- Uses valid/ready handshakes with a registered skid buffer, so back-pressure does not combinationally cross the block.

Parameters:
- LANES, 4, number of independent alignment lanes.
- EXPONENT_WIDTH, 8, exponent width; the difference input is EXPONENT_WIDTH+1 bits signed.
- MANTISSA_WIDTH, 24, signed mantissa width W.
- TAG_WIDTH, 4, opaque sideband carried alongside each beat.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat (registered).
- i_exponent_diff  in  LANES*(EXPONENT_WIDTH+1)  per-lane signed exp_a-exp_b; lane k at slice k.
- i_mantissa_a  in  LANES*W  per-lane signed mantissa A.
- i_mantissa_b  in  LANES*W  per-lane signed mantissa B.
- i_tag  in  TAG_WIDTH  sideband for the beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_exponent_big_a  out  LANES  1 = A had the larger or equal exponent.
- o_mantissa_big  out  LANES*W  unshifted larger-exponent mantissa.
- o_mantissa_aligned  out  LANES*W  shifted smaller mantissa.
- o_guard  out  LANES  first bit below the aligned LSB.
- o_round  out  LANES  second bit below the aligned LSB.
- o_sticky  out  LANES  OR of all bits lost below round.
- o_tag  out  TAG_WIDTH  sideband matching the output beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high:
  - o_valid=0, o_ready=0;
  - skid buffer empty;
  - all data outputs 0.
  - Cycle after rst deasserts: o_ready=1.
  - Reset mid-transfer drops all in-flight beats; no partial output.
- Per-lane combinational datapath (d = exponent_diff, signed):
  - d >= 0: big=A, small=B, exponent_big_a=1.
  - d < 0: big=B, small=A, exponent_big_a=0.
  - d = 0: A is big.
  - Shift amount s = |d|, computed unsigned on EXPONENT_WIDTH+1 bits. d = -2^EXPONENT_WIDTH gives s = 2^EXPONENT_WIDTH without overflow.
  - Extended value X = {small, 2'b00} (W+2 bits). Y = X >>> min(s, W+2), arithmetic, sign-filled.
  - aligned = Y[W+1:2], guard = Y[1], round = Y[0].
  - sticky = OR of X[min(s,W+2)-1:0]: the raw bits lost. Sticky is 0 when s <= 2.
  - s >= W+2: aligned = all sign bits; guard = round = sign; sticky = |small.
- Handshake:
  - Input transfer on i_valid && o_ready. Output transfer on o_valid && i_ready.
  - Latency: 1 cycle from input transfer to o_valid when the downstream is not stalled.
  - Main output register: loads when empty or when its beat transfers out this cycle.
  - Skid register: one extra beat. It captures an accepted beat when the main register is full and not transferring.
  - o_ready = skid empty, registered.
  - Throughput: one beat per cycle with i_ready held high.
  - With i_ready low: at most 2 beats held; o_ready drops the cycle after the skid fills.
  - When the main beat leaves and the skid is full: skid moves to main in the same cycle; o_ready rises the next cycle.
  - Output data and tag stay stable while o_valid=1 && i_ready=0.
  - Beats are never reordered, duplicated or dropped.
- Lanes are fully independent. All lanes share one valid/ready and one tag.

Decomposition:
- Package fp_alu_pkg:
  - default EXPONENT_WIDTH/MANTISSA_WIDTH localparams;
  - helper function for the clamped shift width, $clog2(W+3);
  - a lane-result struct/typedef {big_a, big, aligned, g, r, s} with its packed width constant.
- Sub-module fp_alu_align_lane: purely combinational single-lane swap/shift/GRS logic, instantiated LANES times via generate.
- The top holds the main and skid registers and the handshake control.

Test Plan:
- LANES=1, W=24, A=0x400000, B=0x400000, d=+3 -> big_a=1, big=0x400000, aligned=0x080000, g=0, r=0, sticky=0, o_valid one cycle after accept.
- d=-2, A=0x000007, B=0x100000 -> big_a=0, big=0x100000, aligned=0x000001, g=1, r=1, sticky=0.
  - Same with d=-4 -> aligned=0x000000, g=0, r=1, sticky=1.
- Negative small and large shift:
  - B=0xFFFFF0 (-16), d=+30 -> aligned=0xFFFFFF, g=1, r=1, sticky=1.
  - d=-256 (EXPONENT_WIDTH=8) with A=0 -> aligned=0, sticky=0, no overflow.
- Back-pressure:
  - Stream 6 tagged beats with i_valid=1, holding i_ready=0 for 4 cycles.
  - Required: o_ready falls after 2 beats accepted; output stable while stalled; then i_ready=1 yields tags 0..5 in order with no gaps or duplicates.
- Random i_valid/i_ready over 10k beats, LANES=4, compared against the reference model -> exact per-lane match; o_ready never combinationally dependent on i_ready.
- rst asserted with 2 beats buffered -> next cycle o_valid=0, o_ready=0, outputs 0; after release the first new beat emerges with its own tag.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared defaults, sizing helpers and the per-lane result record
// for the FP ALU alignment stage.
package fp_alu_pkg;

    localparam int DEFAULT_EXPONENT_WIDTH = 8;
    localparam int DEFAULT_MANTISSA_WIDTH = 24;

    // Bits needed to encode a shift clamped to W+2, the extended mantissa width.
    function automatic int shift_width(input int w);
        return $clog2(w + 3);
    endfunction

    function automatic int lane_result_width(input int w);
        return 2 * w + 4;
    endfunction

    typedef struct packed {
        logic                              big_a;
        logic [DEFAULT_MANTISSA_WIDTH-1:0] big;
        logic [DEFAULT_MANTISSA_WIDTH-1:0] aligned;
        logic                              g;
        logic                              r;
        logic                              s;
    } lane_result_t;

    localparam int LANE_RESULT_WIDTH = $bits(lane_result_t);

endpackage

// File: rtl/fp_alu_align_lane.sv
// Single-lane operand swap, arithmetic right shift of the smaller-exponent
// mantissa, and guard/round/sticky extraction. Purely combinational.
module fp_alu_align_lane
    import fp_alu_pkg::*;
#(
    parameter int EXPONENT_WIDTH = DEFAULT_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEFAULT_MANTISSA_WIDTH
) (
    input  logic signed [EXPONENT_WIDTH:0]   i_exponent_diff,
    input  logic        [MANTISSA_WIDTH-1:0] i_mantissa_a,
    input  logic        [MANTISSA_WIDTH-1:0] i_mantissa_b,
    output logic                             o_exponent_big_a,
    output logic        [MANTISSA_WIDTH-1:0] o_mantissa_big,
    output logic        [MANTISSA_WIDTH-1:0] o_mantissa_aligned,
    output logic                             o_guard,
    output logic                             o_round,
    output logic                             o_sticky
);

    localparam int          W           = MANTISSA_WIDTH;
    localparam int          XW          = W + 2;
    localparam int          SHW         = shift_width(W);
    localparam int unsigned SHIFT_LIMIT = XW;
    localparam logic [EXPONENT_WIDTH:0] DIFF_ONE = 1;

    logic                       w_diff_neg;
    logic [EXPONENT_WIDTH:0]    w_diff_bits;
    logic [EXPONENT_WIDTH:0]    w_shift_full;
    logic [SHW-1:0]             w_shift;
    logic [W-1:0]               w_small;
    logic signed [XW-1:0]       w_ext;
    logic signed [XW-1:0]       w_shifted;
    logic [XW-1:0]              w_lost_mask;

    assign w_diff_neg  = i_exponent_diff[EXPONENT_WIDTH];
    assign w_diff_bits = $unsigned(i_exponent_diff);

    // Unsigned negate on EW+1 bits: -2^EW becomes +2^EW rather than wrapping.
    assign w_shift_full = w_diff_neg ? (~w_diff_bits + DIFF_ONE) : w_diff_bits;
    assign w_shift      = (32'(w_shift_full) >= SHIFT_LIMIT) ? SHW'(SHIFT_LIMIT)
                                                             : SHW'(w_shift_full);

    assign o_exponent_big_a = ~w_diff_neg;
    assign o_mantissa_big   = w_diff_neg ? i_mantissa_b : i_mantissa_a;
    assign w_small          = w_diff_neg ? i_mantissa_a : i_mantissa_b;

    assign w_ext       = {w_small, 2'b00};
    assign w_shifted   = w_ext >>> w_shift;
    assign w_lost_mask = ~({XW{1'b1}} << w_shift);

    assign o_mantissa_aligned = w_shifted[XW-1:2];
    assign o_guard            = w_shifted[1];
    assign o_round            = w_shifted[0];
    assign o_sticky           = |(w_ext & w_lost_mask);

endmodule

// File: rtl/fp_alu_align_pipe.sv
// Multi-lane FP alignment stage with a main output register and a one-beat
// skid register so back-pressure never crosses the block combinationally.
module fp_alu_align_pipe
    import fp_alu_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int EXPONENT_WIDTH = DEFAULT_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEFAULT_MANTISSA_WIDTH,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [LANES*(EXPONENT_WIDTH+1)-1:0]   i_exponent_diff,
    input  logic [LANES*MANTISSA_WIDTH-1:0]       i_mantissa_a,
    input  logic [LANES*MANTISSA_WIDTH-1:0]       i_mantissa_b,
    input  logic [TAG_WIDTH-1:0]                  i_tag,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [LANES-1:0]                      o_exponent_big_a,
    output logic [LANES*MANTISSA_WIDTH-1:0]       o_mantissa_big,
    output logic [LANES*MANTISSA_WIDTH-1:0]       o_mantissa_aligned,
    output logic [LANES-1:0]                      o_guard,
    output logic [LANES-1:0]                      o_round,
    output logic [LANES-1:0]                      o_sticky,
    output logic [TAG_WIDTH-1:0]                  o_tag
);

    localparam int W   = MANTISSA_WIDTH;
    localparam int DW  = EXPONENT_WIDTH + 1;
    localparam int LRW = lane_result_width(W);
    localparam int PW  = LANES * LRW + TAG_WIDTH;

    logic [PW-1:0] w_in_beat;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_main_free;
    logic          w_main_valid_next;
    logic          w_skid_valid_next;
    logic          w_load_main_from_skid;
    logic          w_load_main_from_in;
    logic          w_load_skid;

    logic          r_main_valid;
    logic          r_skid_valid;
    logic          r_ready;
    logic [PW-1:0] r_main_beat;
    logic [PW-1:0] r_skid_beat;

    // Beat layout per lane, MSB first: big_a, big, aligned, guard, round, sticky.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic         w_big_a;
        logic [W-1:0] w_big;
        logic [W-1:0] w_aligned;
        logic         w_guard;
        logic         w_round;
        logic         w_sticky;

        fp_alu_align_lane #(
            .EXPONENT_WIDTH (EXPONENT_WIDTH),
            .MANTISSA_WIDTH (MANTISSA_WIDTH)
        ) u_lane (
            .i_exponent_diff    (i_exponent_diff[k*DW +: DW]),
            .i_mantissa_a       (i_mantissa_a[k*W +: W]),
            .i_mantissa_b       (i_mantissa_b[k*W +: W]),
            .o_exponent_big_a   (w_big_a),
            .o_mantissa_big     (w_big),
            .o_mantissa_aligned (w_aligned),
            .o_guard            (w_guard),
            .o_round            (w_round),
            .o_sticky           (w_sticky)
        );

        assign w_in_beat[k*LRW +: LRW] = {w_big_a, w_big, w_aligned, w_guard, w_round, w_sticky};

        assign o_exponent_big_a[k]       = r_main_beat[k*LRW + LRW - 1];
        assign o_mantissa_big[k*W +: W]     = r_main_beat[k*LRW + W + 3 +: W];
        assign o_mantissa_aligned[k*W +: W] = r_main_beat[k*LRW + 3 +: W];
        assign o_guard[k]                = r_main_beat[k*LRW + 2];
        assign o_round[k]                = r_main_beat[k*LRW + 1];
        assign o_sticky[k]               = r_main_beat[k*LRW];
    end

    assign w_in_beat[LANES*LRW +: TAG_WIDTH] = i_tag;
    assign o_tag   = r_main_beat[LANES*LRW +: TAG_WIDTH];
    assign o_valid = r_main_valid;
    assign o_ready = r_ready;

    assign w_in_fire   = i_valid && r_ready;
    assign w_out_fire  = r_main_valid && i_ready;
    assign w_main_free = !r_main_valid || w_out_fire;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        w_main_valid_next     = r_main_valid;
        w_skid_valid_next     = r_skid_valid;
        w_load_main_from_skid = 1'b0;
        w_load_main_from_in   = 1'b0;
        w_load_skid           = 1'b0;
        if (w_main_free) begin
            if (r_skid_valid) begin
                w_load_main_from_skid = 1'b1;
                w_main_valid_next     = 1'b1;
                w_skid_valid_next     = 1'b0;
            end else begin
                w_load_main_from_in = w_in_fire;
                w_main_valid_next   = w_in_fire;
            end
        end else if (w_in_fire) begin
            w_load_skid       = 1'b1;
            w_skid_valid_next = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
            // NOTE: payload registers are reset only because the outputs must read zero during reset.
            r_main_beat  <= '0;
            r_skid_beat  <= '0;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
            r_ready      <= !w_skid_valid_next;
            if (w_load_main_from_skid) begin
                r_main_beat <= r_skid_beat;
            end else if (w_load_main_from_in) begin
                r_main_beat <= w_in_beat;
            end
            if (w_load_skid) begin
                r_skid_beat <= w_in_beat;
            end
        end
    end

endmodule

// File: tb/tb_fp_alu_align_pipe.sv
// Randomized and directed bench for fp_alu_align_pipe against an arithmetic
// reference model with an in-order scoreboard.
module tb_fp_alu_align_pipe;
    import fp_alu_pkg::*;

    localparam int LANES = 4;
    localparam int EW    = 8;
    localparam int W     = 24;
    localparam int TW    = 4;
    localparam int DW    = EW + 1;
    localparam int LRW   = LANE_RESULT_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid;
    logic                  o_ready;
    logic [LANES*DW-1:0]   i_exponent_diff;
    logic [LANES*W-1:0]    i_mantissa_a;
    logic [LANES*W-1:0]    i_mantissa_b;
    logic [TW-1:0]         i_tag;
    logic                  o_valid;
    logic                  i_ready;
    logic [LANES-1:0]      o_exponent_big_a;
    logic [LANES*W-1:0]    o_mantissa_big;
    logic [LANES*W-1:0]    o_mantissa_aligned;
    logic [LANES-1:0]      o_guard;
    logic [LANES-1:0]      o_round;
    logic [LANES-1:0]      o_sticky;
    logic [TW-1:0]         o_tag;

    fp_alu_align_pipe #(
        .LANES          (LANES),
        .EXPONENT_WIDTH (EW),
        .MANTISSA_WIDTH (W),
        .TAG_WIDTH      (TW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_exponent_diff    (i_exponent_diff),
        .i_mantissa_a       (i_mantissa_a),
        .i_mantissa_b       (i_mantissa_b),
        .i_tag              (i_tag),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_exponent_big_a   (o_exponent_big_a),
        .o_mantissa_big     (o_mantissa_big),
        .o_mantissa_aligned (o_mantissa_aligned),
        .o_guard            (o_guard),
        .o_round            (o_round),
        .o_sticky           (o_sticky),
        .o_tag              (o_tag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shift the sign-extended small mantissa (times 4) with plain integer arithmetic.
    function automatic lane_result_t ref_lane(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        lane_result_t res;
        longint       small_v;
        longint       x;
        longint       y;
        int           mag;
        int           sh;
        res.big_a = (d >= 0);
        res.big   = res.big_a ? a : b;
        small_v   = res.big_a ? longint'($signed(b)) : longint'($signed(a));
        mag       = (d < 0) ? -d : d;
        sh        = (mag > W + 2) ? W + 2 : mag;
        x         = small_v * 4;
        y         = x >>> sh;
        res.aligned = y[W+1:2];
        res.g       = y[1];
        res.r       = y[0];
        res.s       = (x != y * (longint'(1) << sh));
        return res;
    endfunction

    function automatic logic [255:0] expected_beat();
        logic [255:0] v;
        lane_result_t res;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            res = ref_lane(int'($signed(i_exponent_diff[k*DW +: DW])),
                           i_mantissa_a[k*W +: W], i_mantissa_b[k*W +: W]);
            v[k*LRW +: LRW] = res;
        end
        v[LANES*LRW +: TW] = i_tag;
        return v;
    endfunction

    function automatic logic [255:0] observed_beat();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*LRW +: LRW] = {o_exponent_big_a[k], o_mantissa_big[k*W +: W],
                               o_mantissa_aligned[k*W +: W], o_guard[k], o_round[k], o_sticky[k]};
        end
        v[LANES*LRW +: TW] = o_tag;
        return v;
    endfunction

    logic [255:0] exp_q[$];
    logic [TW-1:0] out_tags[$];
    logic [255:0] prev_beat;
    logic         have_prev = 1'b0;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [255:0] got;
        logic [255:0] e;
        got = observed_beat();
        if (rst) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) check("stall_stable", got, prev_beat);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {o_valid, got[254:0]}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", got, e);
                    out_tags.push_back(o_tag);
                end
            end
            have_prev = o_valid && !i_ready;
            prev_beat = got;
            if (i_valid && o_ready) exp_q.push_back(expected_beat());
        end
    end

    function automatic logic [DW-1:0] rand_diff();
        int m;
        if ($urandom_range(0, 1) == 0) begin
            m = $urandom_range(0, W + 4);
            return ($urandom_range(0, 1) == 1) ? DW'(-m) : DW'(m);
        end
        return DW'($urandom);
    endfunction

    function automatic logic [W-1:0] rand_mant();
        case ($urandom_range(0, 3))
            0:       return W'($urandom);
            1:       return W'($urandom_range(0, 15));
            2:       return W'(-int'($urandom_range(1, 16)));
            default: return W'($urandom >> $urandom_range(8, 31));
        endcase
    endfunction

    task automatic randomize_inputs();
        for (int k = 0; k < LANES; k++) begin
            i_exponent_diff[k*DW +: DW] = rand_diff();
            i_mantissa_a[k*W +: W]      = rand_mant();
            i_mantissa_b[k*W +: W]      = rand_mant();
        end
    endtask

    // Sends one beat replicated on all lanes and checks lane 0 right after acceptance.
    task automatic directed(input string name, input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TW-1:0] tag, input logic exp_big_a, input logic [W-1:0] exp_big,
                            input logic [W-1:0] exp_aligned, input logic [2:0] exp_grs);
        int n;
        n = 0;
        for (int k = 0; k < LANES; k++) begin
            i_exponent_diff[k*DW +: DW] = DW'(d);
            i_mantissa_a[k*W +: W]      = a;
            i_mantissa_b[k*W +: W]      = b;
        end
        i_tag   = tag;
        i_valid = 1'b1;
        i_ready = 1'b1;
        while (!o_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready"}, o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check({name, "_valid"}, o_valid, 1);
        check({name, "_big_a"}, o_exponent_big_a, {LANES{exp_big_a}});
        check({name, "_big"}, o_mantissa_big[W-1:0], exp_big);
        check({name, "_aligned"}, o_mantissa_aligned[W-1:0], exp_aligned);
        check({name, "_grs"}, {o_guard[0], o_round[0], o_sticky[0]}, exp_grs);
        check({name, "_tag"}, o_tag, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc;
        int  n;
        int  cyc;
        logic fire;
        logic rdy_before;

        rst             = 1'b1;
        i_valid         = 1'b0;
        i_ready         = 1'b0;
        i_exponent_diff = '0;
        i_mantissa_a    = '0;
        i_mantissa_b    = '0;
        i_tag           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_data", {o_mantissa_big, o_mantissa_aligned, o_tag}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_ready", o_ready, 1);

        directed("shr3",  3,    24'h400000, 24'h400000, 4'h1, 1'b1, 24'h400000, 24'h080000, 3'b000);
        directed("neg2",  -2,   24'h000007, 24'h100000, 4'h2, 1'b0, 24'h100000, 24'h000001, 3'b110);
        directed("neg4",  -4,   24'h000007, 24'h100000, 4'h3, 1'b0, 24'h100000, 24'h000000, 3'b011);
        directed("sat30", 30,   24'h123456, 24'hFFFFF0, 4'h4, 1'b1, 24'h123456, 24'hFFFFFF, 3'b111);
        directed("min_d", -256, 24'h000000, 24'h7FFFFF, 4'h5, 1'b0, 24'h7FFFFF, 24'h000000, 3'b000);
        directed("d_zero", 0,   24'h000100, 24'h000003, 4'h6, 1'b1, 24'h000100, 24'h000003, 3'b000);

        // Back-pressure: six tagged beats with the output stalled for four cycles.
        repeat (2) @(posedge clk);
        #1;
        out_tags.delete();
        acc     = 0;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_tag   = '0;
        randomize_inputs();
        for (int c = 0; c < 4; c++) begin
            fire = o_ready;
            @(posedge clk); #1;
            if (fire) begin
                acc++;
                i_tag = TW'(acc);
                randomize_inputs();
            end
        end
        check("bp_accepted", acc, 2);
        check("bp_ready_low", o_ready, 0);
        check("bp_valid", o_valid, 1);
        check("bp_head_tag", o_tag, 0);
        i_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 50) begin
            fire = o_ready;
            @(posedge clk); #1;
            n++;
            if (fire) begin
                acc++;
                i_tag = TW'(acc);
                randomize_inputs();
            end
        end
        i_valid = 1'b0;
        n = 0;
        while ((o_valid || exp_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_drained", exp_q.size(), 0);
        check("bp_count", out_tags.size(), 6);
        for (int i = 0; i < out_tags.size(); i++) check("bp_order", out_tags[i], i);

        // Random traffic with random back-pressure.
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_tag   = TW'($urandom);
            randomize_inputs();
            if (cyc % 64 == 0) begin
                rdy_before = o_ready;
                i_ready = !i_ready;
                #1;
                check("ready_indep", o_ready, rdy_before);
                i_ready = !i_ready;
            end
            fire = i_valid && o_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) acc++;
        end
        check("rand_beats", acc, 10000);
        i_valid = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while ((o_valid || exp_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rand_drained", exp_q.size(), 0);

        // Reset with two beats buffered.
        acc     = 0;
        n       = 0;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_tag   = 4'hA;
        randomize_inputs();
        while (acc < 2 && n < 20) begin
            fire = o_ready;
            @(posedge clk); #1;
            n++;
            if (fire) begin
                acc++;
                i_tag = 4'hB;
                randomize_inputs();
            end
        end
        check("rst_pre_ready", o_ready, 0);
        check("rst_pre_valid", o_valid, 1);
        i_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_ready", o_ready, 0);
        check("rst_mid_data", {o_exponent_big_a, o_mantissa_big, o_mantissa_aligned,
                               o_guard, o_round, o_sticky, o_tag}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rel_ready", o_ready, 1);
        directed("post_rst", 3, 24'h400000, 24'h400000, 4'h9, 1'b1, 24'h400000, 24'h080000, 3'b000);
        check("post_rst_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
